// File: rtl/reg_set.sv
// reg_set: RV32 integer register file.
// Two combinational read ports, one synchronous write port, register 0 hard-wired to zero.
// Optional feature macro: REGSET_RESET_EN
//   defined   -> registers 1..N-1 get an asynchronous active-low clear; reset beats write.
//   undefined -> reset is ignored and the array has no reset (RAM-inference friendly).
module reg_set #(
    parameter int unsigned REGISTER_COUNT = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = $clog2(REGISTER_COUNT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read1_addr,
    input  logic [ADDR_WIDTH-1:0] read2_addr,
    output logic [DATA_WIDTH-1:0] read1_data,
    output logic [DATA_WIDTH-1:0] read2_data
);

    // Entry 0 is never stored; only 1..REGISTER_COUNT-1 exist as flops.
    logic [DATA_WIDTH-1:0] regs [1:REGISTER_COUNT-1];

    logic write_hit;
    assign write_hit = write_enable && (write_addr != '0);

`ifdef REGSET_RESET_EN
    // Writeback port with asynchronous clear; an active reset suppresses the write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < int'(REGISTER_COUNT); i++) begin
                regs[i] <= '0;
            end
        end else if (write_hit) begin
            regs[write_addr] <= write_data;
        end
    end
`else
    // Reset is accepted at the port but intentionally has no effect in this build.
    logic unused_reset;
    assign unused_reset = reset;

    // Writeback port without reset so the array can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (write_hit) begin
            regs[write_addr] <= write_data;
        end
    end
`endif

    // Read port 1: address 0 forces zero, no bypass from the write port.
    always_comb begin
        read1_data = '0;
        if (read1_addr != '0) begin
            read1_data = regs[read1_addr];
        end
    end

    // Read port 2: independent of port 1, same zero-register rule.
    always_comb begin
        read2_data = '0;
        if (read2_addr != '0) begin
            read2_data = regs[read2_addr];
        end
    end

endmodule

// File: tb/tb_reg_set.sv
// Self-checking bench for reg_set: directed scenarios plus randomized traffic
// compared against an array-based reference model. Honors REGSET_RESET_EN.
module tb_reg_set;

    localparam int unsigned N  = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clk;
    logic          reset;
    logic          write_enable;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;
    logic [AW-1:0] read1_addr;
    logic [AW-1:0] read2_addr;
    logic [DW-1:0] read1_data;
    logic [DW-1:0] read2_data;

    int checks;
    int errors;

    // Reference model: architectural register contents.
    logic [DW-1:0] model [N];

    reg_set #(.REGISTER_COUNT(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .read1_addr   (read1_addr),
        .read2_addr   (read2_addr),
        .read1_data   (read1_data),
        .read2_data   (read2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef REGSET_RESET_EN
    localparam bit RESET_EN = 1'b1;
`else
    localparam bit RESET_EN = 1'b0;
`endif

    function automatic logic [DW-1:0] expect_read(input int a);
        return (a == 0) ? '0 : model[a];
    endfunction

    // Apply one clock edge's worth of write, updating the model by the architectural rules.
    task automatic clock_write(input int a, input logic [DW-1:0] d, input bit we);
        @(negedge clk);
        write_enable = we;
        write_addr   = AW'(a);
        write_data   = d;
        @(posedge clk);
        if (we && a != 0 && (!RESET_EN || reset)) model[a] = d;
        #1;
        write_enable = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b0;
        write_enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        if (RESET_EN) begin
            for (int i = 0; i < int'(N); i++) begin
                read1_addr = AW'(i);
                read2_addr = AW'(N - 1 - i);
                #1;
                checks++;
                if (read1_data !== '0 || read2_data !== '0) begin
                    errors++;
                    $display("FAIL test_reset addr %0d: read1=%h read2=%h required 0", i, read1_data, read2_data);
                end
            end
            for (int i = 0; i < int'(N); i++) model[i] = '0;
        end else begin
            read1_addr = '0;
            read2_addr = '0;
            #1;
            checks++;
            if (read1_data !== '0 || read2_data !== '0) begin
                errors++;
                $display("FAIL test_reset r0: read1=%h read2=%h required 0", read1_data, read2_data);
            end
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic;
        clock_write(1, 32'd42, 1'b1);
        clock_write(2, 32'd69, 1'b1);
        read1_addr = 5'd1;
        read2_addr = 5'd2;
        #1;
        checks++;
        if (read1_data !== 32'd42) begin
            errors++;
            $display("FAIL test_basic read1: got %0d required 42", read1_data);
        end
        checks++;
        if (read2_data !== 32'd69) begin
            errors++;
            $display("FAIL test_basic read2: got %0d required 69", read2_data);
        end
    endtask

    task automatic test_fill(input logic [DW-1:0] base);
        for (int i = 0; i < int'(N); i++) clock_write(i, base + DW'(i), 1'b1);
        for (int i = 1; i < int'(N) - 1; i += 2) begin
            read1_addr = AW'(i);
            read2_addr = AW'(i + 1);
            #1;
            checks++;
            if (read1_data !== base + DW'(i) || read2_data !== base + DW'(i + 1)) begin
                errors++;
                $display("FAIL test_fill pair %0d: read1=%h read2=%h required %h %h",
                         i, read1_data, read2_data, base + DW'(i), base + DW'(i + 1));
            end
        end
    endtask

    task automatic test_zero_reg;
        read1_addr = '0;
        read2_addr = '0;
        #1;
        checks++;
        if (read1_data !== '0 || read2_data !== '0) begin
            errors++;
            $display("FAIL test_zero_reg: read1=%h read2=%h required 0", read1_data, read2_data);
        end
    endtask

    // Reset held low while writing 37 everywhere: with reset compiled in nothing lands.
    task automatic test_reset_with_write;
        @(negedge clk);
        reset = 1'b0;
        if (RESET_EN) for (int i = 0; i < int'(N); i++) model[i] = '0;
        for (int i = 0; i < int'(N); i++) begin
            clock_write(i, 32'd37, 1'b1);
            read1_addr = AW'(i);
            read2_addr = AW'((i + 7) % int'(N));
            #1;
            checks++;
            if (read1_data !== expect_read(i) || read2_data !== expect_read((i + 7) % int'(N))) begin
                errors++;
                $display("FAIL test_reset_with_write addr %0d: read1=%h read2=%h required %h %h",
                         i, read1_data, read2_data, expect_read(i), expect_read((i + 7) % int'(N)));
            end
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < int'(N); i++) begin
            read1_addr = AW'(i);
            #1;
            checks++;
            if (read1_data !== expect_read(i)) begin
                errors++;
                $display("FAIL test_reset_with_write after addr %0d: got %h required %h", i, read1_data, expect_read(i));
            end
        end
    endtask

    task automatic test_reset_pulse;
        @(negedge clk);
        write_enable = 1'b0;
        reset = 1'b0;
        if (RESET_EN) for (int i = 0; i < int'(N); i++) model[i] = '0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < int'(N); i++) begin
            read1_addr = AW'(i);
            read2_addr = AW'(N - 1 - i);
            #1;
            checks++;
            if (read1_data !== expect_read(i) || read2_data !== expect_read(int'(N) - 1 - i)) begin
                errors++;
                $display("FAIL test_reset_pulse addr %0d: read1=%h read2=%h required %h %h",
                         i, read1_data, read2_data, expect_read(i), expect_read(int'(N) - 1 - i));
            end
        end
    endtask

    task automatic test_same_cycle;
        clock_write(5, 32'd7, 1'b1);
        @(negedge clk);
        write_enable = 1'b1;
        write_addr   = 5'd5;
        write_data   = 32'd9;
        read1_addr   = 5'd5;
        #1;
        checks++;
        if (read1_data !== 32'd7) begin
            errors++;
            $display("FAIL test_same_cycle before: got %0d required 7", read1_data);
        end
        @(posedge clk);
        model[5] = 32'd9;
        #1;
        write_enable = 1'b0;
        checks++;
        if (read1_data !== 32'd9) begin
            errors++;
            $display("FAIL test_same_cycle after: got %0d required 9", read1_data);
        end
    endtask

    task automatic test_random(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            int wa, r1, r2;
            bit we;
            logic [DW-1:0] wd;
            we = 1'($urandom_range(0, 3) != 0);
            wa = int'($urandom_range(0, N - 1));
            wd = $urandom;
            r1 = int'($urandom_range(0, N - 1));
            r2 = ($urandom_range(0, 3) == 0) ? r1 : int'($urandom_range(0, N - 1));
            @(negedge clk);
            write_enable = we;
            write_addr   = AW'(wa);
            write_data   = wd;
            read1_addr   = AW'(r1);
            read2_addr   = AW'(r2);
            #1;
            checks++;
            if (read1_data !== expect_read(r1) || read2_data !== expect_read(r2)) begin
                errors++;
                $display("FAIL test_random cycle %0d r1=%0d r2=%0d: got %h %h required %h %h",
                         c, r1, r2, read1_data, read2_data, expect_read(r1), expect_read(r2));
            end
            @(posedge clk);
            if (we && wa != 0) model[wa] = wd;
        end
        @(negedge clk);
        write_enable = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        write_enable = 1'b0;
        write_addr = '0;
        write_data = '0;
        read1_addr = '0;
        read2_addr = '0;
        for (int i = 0; i < int'(N); i++) model[i] = 'x;
        model[0] = '0;

        test_reset;
        test_basic;
        test_fill($urandom);
        test_zero_reg;
        test_same_cycle;
        test_reset_pulse;
        test_fill($urandom);
        test_reset_with_write;
        test_fill($urandom);
        test_random(300);
        test_zero_reg;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
